// File: rtl/addern_rr_sched_if.sv
// Request/response bundle between client blocks and the shared-adder scheduler.
interface addern_rr_sched_if #(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_x;
    logic [NREQ*N-1:0] req_y;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;

    // Client side: raises requests, consumes responses.
    modport master (
        output req, req_x, req_y, req_cin, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    // Scheduler side.
    modport slave (
        input  req, req_x, req_y, req_cin, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/addern_rr_sched.sv
// Round-robin scheduler sharing one combinational ripple adder among NREQ
// requesters. One op at a time: IDLE (grant + latch operands) -> EXEC
// (adder settles) -> RESP (hold result until the consumer takes it).
module addern_rr_sched #(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic           clk,
    input  logic           sreset,
    addern_rr_sched_if.slave bus,
    output logic           busy,
    output logic [N-1:0]   adder_x,
    output logic [N-1:0]   adder_y,
    output logic           adder_cin,
    input  logic [N-1:0]   adder_s,
    input  logic           adder_cout
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [IDW-1:0] PTR_INIT = IDW'(NREQ - 1);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           any;
    logic [N-1:0]   sel_x;
    logic [N-1:0]   sel_y;
    logic           sel_cin;

    // Rotating priority scan: first set request after the last winner.
    always_comb begin
        int idx;
        any = 1'b0;
        win = '0;
        idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && bus.req[idx]) begin
                any = 1'b1;
                win = IDW'(idx);
            end
        end
    end

    // Operand mux for the winning requester (constant slices keep it simple).
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_x   = bus.req_x[i*N +: N];
                sel_y   = bus.req_y[i*N +: N];
                sel_cin = bus.req_cin[i];
            end
        end
    end

    // Grant is combinational and only offered in IDLE; masked during reset.
    assign bus.gnt = (state == IDLE && any && !sreset)
                     ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
    assign busy    = (state != IDLE);

    // Scheduler FSM with registered adder operands and response fields.
    always_ff @(posedge clk or posedge sreset) begin
        if (sreset) begin
            state         <= IDLE;
            ptr           <= PTR_INIT;
            adder_x       <= '0;
            adder_y       <= '0;
            adder_cin     <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        adder_x    <= sel_x;
                        adder_y    <= sel_y;
                        adder_cin  <= sel_cin;
                        bus.rsp_id <= win;
                        ptr        <= win;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable a full cycle; ripple chain is settled.
                    bus.rsp_sum   <= adder_s;
                    bus.rsp_cout  <= adder_cout;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
